// File: rtl/ram_sync_fifo_if.sv
// rtl/ram_sync_fifo_if.sv - producer/consumer bus of the single-clock RAM FIFO
interface ram_sync_fifo_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
);
   logic                  FLUSH;
   logic [DATA_WIDTH-1:0] WR_DI;
   logic                  WR_EN;
   logic                  RD_EN;
   logic [DATA_WIDTH-1:0] RD_DO;
   logic                  RD_VALID;
   logic                  FULL;
   logic                  EMPTY;
   logic                  AFULL;
   logic                  AEMPTY;
   logic [ADDR_WIDTH:0]   COUNT;
   logic                  OVERFLOW;
   logic                  UNDERFLOW;

   // Producer/consumer side drives requests and observes status
   modport master (
      output FLUSH, WR_DI, WR_EN, RD_EN,
      input  RD_DO, RD_VALID, FULL, EMPTY, AFULL, AEMPTY, COUNT, OVERFLOW, UNDERFLOW
   );

   // FIFO side consumes requests and reports status
   modport slave (
      input  FLUSH, WR_DI, WR_EN, RD_EN,
      output RD_DO, RD_VALID, FULL, EMPTY, AFULL, AEMPTY, COUNT, OVERFLOW, UNDERFLOW
   );
endinterface

// File: rtl/ram_sync_fifo.sv
// rtl/ram_sync_fifo.sv - single-clock FIFO over a registered-read dual-port RAM
module ram_sync_fifo #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDR_WIDTH    = 8,
   parameter int AFULL_THRESH  = 2**ADDR_WIDTH-2,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic           CLK,
   input  logic           RST_N,
   ram_sync_fifo_if.slave bus
);
   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] C_DEPTH  = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] C_AFULL  = (ADDR_WIDTH+1)'(AFULL_THRESH);
   localparam logic [ADDR_WIDTH:0] C_AEMPTY = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
   localparam logic [ADDR_WIDTH:0] C_CNT_ONE = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] C_PTR_ONE = ADDR_WIDTH'(1);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic [DATA_WIDTH-1:0] r_rd_do;
   logic                  r_rd_valid;
   logic                  r_overflow;
   logic                  r_underflow;

   logic w_full;
   logic w_empty;
   logic w_wr_acc;
   logic w_rd_acc;
   logic w_mem_we;

   // Status decoded only from registered occupancy, so requests never reach outputs combinationally
   assign w_full  = (r_count == C_DEPTH);
   assign w_empty = (r_count == '0);

   // When full the write loses; when empty the read loses, so read and write addresses never collide
   assign w_wr_acc = bus.WR_EN && !w_full;
   assign w_rd_acc = bus.RD_EN && !w_empty;
   assign w_mem_we = RST_N && !bus.FLUSH && w_wr_acc;

   // RAM array: no reset, contents survive reset and flush
   always_ff @(posedge CLK) begin
      if (w_mem_we) begin
         r_mem[r_wr_ptr] <= bus.WR_DI;
      end
   end

   // Pointers, occupancy, registered read port and sticky error flags
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_rd_do     <= '0;
         r_rd_valid  <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (bus.FLUSH) begin
         // Same clear as reset, but the last read word stays visible
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_rd_valid  <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_rd_valid <= w_rd_acc;
         if (w_rd_acc) begin
            r_rd_do  <= r_mem[r_rd_ptr];
            r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
         end
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
         end
         if (bus.WR_EN && w_full) begin
            r_overflow <= 1'b1;
         end
         if (bus.RD_EN && w_empty) begin
            r_underflow <= 1'b1;
         end
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_count <= r_count + C_CNT_ONE;
            2'b01:   r_count <= r_count - C_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   assign bus.RD_DO     = r_rd_do;
   assign bus.RD_VALID  = r_rd_valid;
   assign bus.FULL      = w_full;
   assign bus.EMPTY     = w_empty;
   assign bus.AFULL     = (r_count >= C_AFULL);
   assign bus.AEMPTY    = (r_count <= C_AEMPTY);
   assign bus.COUNT     = r_count;
   assign bus.OVERFLOW  = r_overflow;
   assign bus.UNDERFLOW = r_underflow;
endmodule

// File: tb/tb_ram_sync_fifo.sv
// tb/tb_ram_sync_fifo.sv - vector table plus read-data scoreboard for ram_sync_fifo
module tb_ram_sync_fifo;
   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   ram_sync_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

   ram_sync_fifo #(
      .DATA_WIDTH(8),
      .ADDR_WIDTH(3),
      .AFULL_THRESH(6),
      .AEMPTY_THRESH(1)
   ) dut (
      .CLK(clk),
      .RST_N(rst_n),
      .bus(bus)
   );

   typedef struct {
      logic       rst_n;
      logic       flush;
      logic       wr;
      logic       rd;
      logic [7:0] di;
      logic [3:0] cnt;
      logic       full;
      logic       empty;
      logic       afull;
      logic       aempty;
      logic       ovf;
      logic       unf;
   } vec_t;

   vec_t       vecs[$];
   logic [7:0] mdl_q[$];
   logic [7:0] exp_rd_q[$];
   int         n_checks = 0;
   int         n_errors = 0;

   function automatic void add(input logic r, input logic f, input logic w, input logic rd,
                               input logic [7:0] di, input logic [3:0] cnt,
                               input logic ovf, input logic unf);
      vec_t v;
      v.rst_n = r;  v.flush = f;  v.wr = w;  v.rd = rd;  v.di = di;  v.cnt = cnt;
      v.full   = (cnt == 4'd8);
      v.empty  = (cnt == 4'd0);
      v.afull  = (cnt >= 4'd6);
      v.aempty = (cnt <= 4'd1);
      v.ovf = ovf;  v.unf = unf;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      logic wr_ok;
      logic rd_ok;
      rst_n     = v.rst_n;
      bus.FLUSH = v.flush;
      bus.WR_EN = v.wr;
      bus.RD_EN = v.rd;
      bus.WR_DI = v.di;
      if (!v.rst_n) begin
         mdl_q.delete();
         exp_rd_q.delete();
      end else if (v.flush) begin
         mdl_q.delete();
      end else begin
         wr_ok = v.wr && (mdl_q.size() < 8);
         rd_ok = v.rd && (mdl_q.size() > 0);
         if (rd_ok) exp_rd_q.push_back(mdl_q.pop_front());
         if (wr_ok) mdl_q.push_back(v.di);
      end
      @(negedge clk);
      if (bus.RD_VALID) begin
         if (exp_rd_q.size() == 0) chk("rd_valid_spurious", idx, 32'(bus.RD_VALID), 32'd0);
         else chk("rd_do", idx, 32'(bus.RD_DO), 32'(exp_rd_q.pop_front()));
      end else if (exp_rd_q.size() > 0) begin
         chk("rd_valid_missing", idx, 32'(bus.RD_VALID), 32'd1);
         void'(exp_rd_q.pop_front());
      end
      chk("count", idx, 32'(bus.COUNT), 32'(v.cnt));
      chk("flags{full,empty,afull,aempty,ovf,unf}", idx,
          32'({bus.FULL, bus.EMPTY, bus.AFULL, bus.AEMPTY, bus.OVERFLOW, bus.UNDERFLOW}),
          32'({v.full, v.empty, v.afull, v.aempty, v.ovf, v.unf}));
   endtask

   initial begin
      rst_n = 1'b0;  bus.FLUSH = 1'b0;  bus.WR_EN = 1'b0;  bus.RD_EN = 1'b0;  bus.WR_DI = 8'h00;

      add(0, 0, 0, 0, 8'h00, 4'd0, 0, 0);
      // fill and drain
      for (int i = 0; i < 8; i++) add(1, 0, 1, 0, 8'(8'h10 + i), 4'(i + 1), 0, 0);
      for (int i = 0; i < 8; i++) add(1, 0, 0, 1, 8'h00, 4'(7 - i), 0, 0);
      // wrap-around at constant occupancy 3
      for (int i = 0; i < 3; i++) add(1, 0, 1, 0, 8'(i), 4'(i + 1), 0, 0);
      for (int i = 0; i < 20; i++) add(1, 0, 1, 1, 8'(3 + i), 4'd3, 0, 0);
      for (int i = 0; i < 3; i++) add(1, 0, 0, 1, 8'h00, 4'(2 - i), 0, 0);
      // overflow then underflow
      for (int i = 0; i < 9; i++) add(1, 0, 1, 0, 8'(8'h20 + i), (i < 8) ? 4'(i + 1) : 4'd8, (i == 8), 0);
      for (int i = 0; i < 8; i++) add(1, 0, 0, 1, 8'h00, 4'(7 - i), 1, 0);
      add(1, 0, 0, 1, 8'h00, 4'd0, 1, 1);
      // simultaneous requests at full and empty
      add(0, 0, 0, 0, 8'h00, 4'd0, 0, 0);
      for (int i = 0; i < 8; i++) add(1, 0, 1, 0, 8'(8'h30 + i), 4'(i + 1), 0, 0);
      add(1, 0, 1, 1, 8'hAA, 4'd7, 1, 0);
      for (int i = 0; i < 7; i++) add(1, 0, 0, 1, 8'h00, 4'(6 - i), 1, 0);
      add(1, 0, 1, 1, 8'h55, 4'd1, 1, 1);
      add(1, 0, 0, 1, 8'h00, 4'd0, 1, 1);
      // flush with a concurrent write
      for (int i = 0; i < 5; i++) add(1, 0, 1, 0, 8'(8'h40 + i), 4'(i + 1), 1, 1);
      add(1, 1, 1, 0, 8'h99, 4'd0, 0, 0);
      add(1, 0, 1, 0, 8'h3C, 4'd1, 0, 0);
      add(1, 0, 0, 1, 8'h00, 4'd0, 0, 0);
      // preload for the reset-mid-read sequence
      for (int i = 0; i < 5; i++) add(1, 0, 1, 0, 8'(8'h50 + i), 4'(i + 1), 0, 0);
      add(1, 0, 0, 1, 8'h00, 4'd4, 0, 0);

      run_vec(0, vecs[0]);
      chk("reset_rd_do", 0, 32'(bus.RD_DO), 32'd0);
      for (int i = 1; i < vecs.size(); i++) run_vec(i, vecs[i]);

      // reset dropped while a read is in flight: nothing moves before the edge
      rst_n = 1'b0;  bus.RD_EN = 1'b1;  bus.WR_EN = 1'b0;  bus.FLUSH = 1'b0;
      #1;
      chk("pre_edge_count", -1, 32'(bus.COUNT), 32'd4);
      chk("pre_edge_rd_valid", -1, 32'(bus.RD_VALID), 32'd1);
      chk("pre_edge_rd_do", -1, 32'(bus.RD_DO), 32'h50);
      @(negedge clk);
      mdl_q.delete();
      exp_rd_q.delete();
      chk("rst_count", -1, 32'(bus.COUNT), 32'd0);
      chk("rst_rd_do", -1, 32'(bus.RD_DO), 32'd0);
      chk("rst_rd_valid", -1, 32'(bus.RD_VALID), 32'd0);
      chk("rst_empty", -1, 32'(bus.EMPTY), 32'd1);
      chk("rst_aempty", -1, 32'(bus.AEMPTY), 32'd1);
      rst_n = 1'b1;  bus.RD_EN = 1'b0;
      @(negedge clk);
      chk("post_rst_rd_valid", -1, 32'(bus.RD_VALID), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
